// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Each digit gets REFRESH_DIV cycles; the first GUARD cycles of a slot keep all
// anodes off so the segment lines can settle without ghosting onto the next digit.
// Outputs are registered: they reflect the scan state of the previous cycle.
module seg7_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [3:0]  dp_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame
);
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   disp;
    logic          terminal;
    logic [3:0]    zero;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    glyph;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;
    logic          frame_d;

    assign terminal = (cnt == CNT_LAST);

    assign zero[0] = (disp[3:0]   == 4'd0);
    assign zero[1] = (disp[7:4]   == 4'd0);
    assign zero[2] = (disp[11:8]  == 4'd0);
    assign zero[3] = (disp[15:12] == 4'd0);

    // Prescaler counts through the slot; digit index advances on its wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (terminal) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Display register: capture on load, reset has priority over load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp <= 16'h0000;
        end else if (load) begin
            disp <= bcd;
        end
    end

    // Select the nibble of the current digit and decide leading-zero blanking
    always_comb begin
        nib   = disp[3:0];
        blank = 1'b0;
        case (idx)
            2'd3: begin nib = disp[15:12]; blank = zero[3];                     end
            2'd2: begin nib = disp[11:8];  blank = zero[3] & zero[2];           end
            2'd1: begin nib = disp[7:4];   blank = zero[3] & zero[2] & zero[1]; end
            default: begin nib = disp[3:0]; blank = 1'b0;                       end
        endcase
        blank = blank & blank_lz;
    end

    // Nibble to active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash
    always_comb begin
        case (nib)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = 7'b0111111;
        endcase
    end

    // Next output values: all dark during the guard, else drive the active digit
    always_comb begin
        an_d    = 4'b1111;
        seg_d   = 7'h7F;
        dp_d    = 1'b1;
        frame_d = terminal && (idx == 2'd3);
        if (cnt >= CNT_GUARD) begin
            an_d  = ~(4'b0001 << idx);
            seg_d = blank ? 7'h7F : glyph;
            dp_d  = ~dp_en[idx];
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an    <= 4'b1111;
            seg   <= 7'h7F;
            dp    <= 1'b1;
            frame <= 1'b0;
        end else begin
            an    <= an_d;
            seg   <= seg_d;
            dp    <= dp_d;
            frame <= frame_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: scoreboard bench for seg7_scan with REFRESH_DIV=8, GUARD=2.
// Inputs change on the falling edge; the expected registered outputs for the
// coming rising edge are pushed to exp_q and popped #1 after that edge.
module tb_seg7_scan;
  localparam int DIV = 8;
  localparam int GRD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bcd = 16'h0000;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  dp_en = 4'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  always #5 clk = ~clk;

  seg7_scan #(.REFRESH_DIV(DIV), .GUARD(GRD)) dut (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .load(load), .blank_lz(blank_lz),
    .dp_en(dp_en), .an(an), .seg(seg), .dp(dp), .frame(frame)
  );

  // {frame, dp, seg, an}
  logic [12:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  // reference scan position and display value
  int          m_cnt = 0;
  int          m_idx = 0;
  logic [15:0] m_disp = 16'h0000;
  // position whose outputs appear after the latest edge
  int          p_cnt = 0;
  int          p_idx = 0;

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [12:0] exp_out(input int c, input int i, input logic [15:0] d,
                                          input logic blz, input logic [3:0] dpe);
    logic [3:0] a;
    logic [6:0] s;
    logic       p;
    logic       f;
    logic       zero_above;
    f = (c == DIV - 1) && (i == 3);
    a = 4'hF;
    s = 7'h7F;
    p = 1'b1;
    if (c >= GRD) begin
      a[i] = 1'b0;
      zero_above = 1'b1;
      for (int k = i; k < 4; k++) if (d[k*4 +: 4] != 4'd0) zero_above = 1'b0;
      s = (blz && i != 0 && zero_above) ? 7'h7F : dec(d[i*4 +: 4]);
      p = ~dpe[i];
    end
    return {f, p, s, a};
  endfunction

  // drive one cycle, queue the expected outputs, advance the reference model
  task automatic step(input logic r, input logic ld, input logic [15:0] b,
                      input logic blz, input logic [3:0] dpe);
    @(negedge clk);
    rst_n = r; load = ld; bcd = b; blank_lz = blz; dp_en = dpe;
    p_cnt = m_cnt;
    p_idx = m_idx;
    if (!r) begin
      exp_q.push_back({1'b0, 1'b1, 7'h7F, 4'hF});
      m_cnt = 0; m_idx = 0; m_disp = 16'h0000;
      p_cnt = 0; p_idx = 0;
    end else begin
      exp_q.push_back(exp_out(m_cnt, m_idx, m_disp, blz, dpe));
      if (ld) m_disp = b;
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] e;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
      e = exp_q.pop_front(); checks++;
      if ({frame, dp, seg, an} !== e) $display("FAIL reset_sb got=%b exp=%b", {frame, dp, seg, an}, e);
      else passes++;
    end
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame !== 1'b0)
      $display("FAIL reset_vals got an=%b seg=%b dp=%b frame=%b exp 1111/1111111/1/0", an, seg, dp, frame);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
      e = exp_q.pop_front(); checks++;
      if ({frame, dp, seg, an} !== e) $display("FAIL reset_start_sb got=%b exp=%b", {frame, dp, seg, an}, e);
      else passes++;
    end
    // third cycle out of reset is the first non-guard cycle of digit 0
    checks++;
    if (an !== 4'b1110 || seg !== 7'b1000000)
      $display("FAIL reset_first_digit got an=%b seg=%b exp an=1110 seg=1000000", an, seg);
    else passes++;
  endtask

  task automatic test_scan_1234();
    logic [12:0] e;
    logic [6:0]  ts[4];
    logic [3:0]  ta[4];
    ts = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    ta = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    step(1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    void'(exp_q.pop_front());
    step(1'b1, 1'b1, 16'h1234, 1'b0, 4'h0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 16'h1234, 1'b0, 4'h0);
      e = exp_q.pop_front(); checks++;
      if ({frame, dp, seg, an} !== e) $display("FAIL scan_sb got=%b exp=%b", {frame, dp, seg, an}, e);
      else passes++;
      checks++;
      if (p_cnt < GRD) begin
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1)
          $display("FAIL scan_guard got an=%b seg=%b dp=%b exp 1111/1111111/1", an, seg, dp);
        else passes++;
      end else begin
        if (an !== ta[p_idx] || seg !== ts[p_idx] || dp !== 1'b1)
          $display("FAIL scan_digit%0d got an=%b seg=%b dp=%b exp an=%b seg=%b dp=1",
                   p_idx, an, seg, dp, ta[p_idx], ts[p_idx]);
        else passes++;
      end
    end
  endtask

  task automatic test_blanking();
    logic [12:0] e;
    logic [15:0] pv[3];
    logic [6:0]  ts[3][4];
    pv = '{16'h0042, 16'h0000, 16'h0A05};
    ts[0] = '{7'b0100100, 7'b0011001, 7'h7F, 7'h7F};
    ts[1] = '{7'b1000000, 7'h7F, 7'h7F, 7'h7F};
    ts[2] = '{7'b0010010, 7'b1000000, 7'b0111111, 7'h7F};
    for (int j = 0; j < 3; j++) begin
      step(1'b1, 1'b1, pv[j], 1'b1, 4'h0);
      void'(exp_q.pop_front());
      for (int i = 0; i < 32; i++) begin
        step(1'b1, 1'b0, pv[j], 1'b1, 4'h0);
        e = exp_q.pop_front(); checks++;
        if ({frame, dp, seg, an} !== e) $display("FAIL blank_sb got=%b exp=%b", {frame, dp, seg, an}, e);
        else passes++;
        if (p_cnt >= GRD) begin
          checks++;
          if (seg !== ts[j][p_idx] || an[p_idx] !== 1'b0)
            $display("FAIL blank_%h_digit%0d got seg=%b an=%b exp seg=%b", pv[j], p_idx, seg, an, ts[j][p_idx]);
          else passes++;
        end
      end
    end
  endtask

  task automatic test_midslot_load();
    logic [12:0] e;
    step(1'b0, 1'b0, 16'h0, 1'b0, 4'b0010);
    void'(exp_q.pop_front());
    for (int i = 0; i < 64 && !(m_idx == 1 && m_cnt == 5); i++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0, 4'b0010);
      void'(exp_q.pop_front());
    end
    step(1'b1, 1'b1, 16'h5555, 1'b0, 4'b0010);
    void'(exp_q.pop_front());
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0, 4'b0010);
      e = exp_q.pop_front(); checks++;
      if ({frame, dp, seg, an} !== e) $display("FAIL midload_sb got=%b exp=%b", {frame, dp, seg, an}, e);
      else passes++;
      if (p_cnt >= GRD) begin
        checks++;
        if (p_idx == 1 && (seg !== 7'b0010010 || dp !== 1'b0))
          $display("FAIL midload_digit1 got seg=%b dp=%b exp seg=0010010 dp=0", seg, dp);
        else if (p_idx != 1 && (seg !== 7'b0010010 || dp !== 1'b1))
          $display("FAIL midload_digit%0d got seg=%b dp=%b exp seg=0010010 dp=1", p_idx, seg, dp);
        else passes++;
      end
    end
  endtask

  task automatic test_frame();
    logic [12:0] e;
    int n_pulse;
    int first;
    int last;
    n_pulse = 0; first = -1; last = -1;
    step(1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
      e = exp_q.pop_front(); checks++;
      if ({frame, dp, seg, an} !== e) $display("FAIL frame_sb got=%b exp=%b", {frame, dp, seg, an}, e);
      else passes++;
      if (frame === 1'b1) begin
        n_pulse++;
        if (first < 0) first = i;
        else last = i;
      end
    end
    checks++;
    if (n_pulse != 2) $display("FAIL frame_count got=%0d exp=2", n_pulse);
    else passes++;
    checks++;
    if (first != 31 || last - first != 32)
      $display("FAIL frame_spacing got first=%0d gap=%0d exp first=31 gap=32", first, last - first);
    else passes++;
  endtask

  task automatic test_reset_override();
    logic [12:0] e;
    step(1'b1, 1'b1, 16'h1234, 1'b0, 4'h0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 64 && !(m_idx == 2 && m_cnt == 4); i++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
      void'(exp_q.pop_front());
    end
    step(1'b0, 1'b1, 16'h9999, 1'b0, 4'h0);
    e = exp_q.pop_front(); checks++;
    if ({frame, dp, seg, an} !== e) $display("FAIL ovr_sb got=%b exp=%b", {frame, dp, seg, an}, e);
    else passes++;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame !== 1'b0)
      $display("FAIL ovr_outputs got an=%b seg=%b dp=%b frame=%b exp 1111/1111111/1/0", an, seg, dp, frame);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
      e = exp_q.pop_front(); checks++;
      if ({frame, dp, seg, an} !== e) $display("FAIL ovr_restart_sb got=%b exp=%b", {frame, dp, seg, an}, e);
      else passes++;
    end
    checks++;
    if (an !== 4'b1110 || seg !== 7'b1000000)
      $display("FAIL ovr_restart got an=%b seg=%b exp an=1110 seg=1000000", an, seg);
    else passes++;
  endtask

  task automatic test_random();
    logic [12:0] e;
    logic [15:0] b;
    step(1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 4; k++)
        b[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      step(1'b1, $urandom_range(0, 3) == 0, b, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      e = exp_q.pop_front(); checks++;
      if ({frame, dp, seg, an} !== e) $display("FAIL random_sb cycle=%0d got=%b exp=%b", i, {frame, dp, seg, an}, e);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_scan_1234();
    test_blanking();
    test_midslot_load();
    test_frame();
    test_reset_override();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000; clock cycles per digit slot, legal range >= 4.
REQ-002 SHALL have parameter GUARD, default 16; anode-off cycles at the start of each slot, legal range 1..REFRESH_DIV-2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port bcd  input  16  four packed BCD digits, [15:12] = thousands (digit 3) down to [3:0] = units (digit 0), as produced by the upstream binary-to-BCD converter.
REQ-006 SHALL have port load  input  1  when high, bcd is captured into the display register.
REQ-007 SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-008 SHALL have port dp_en  input  4  per-digit decimal-point enable; bit k controls digit k; sampled live.
REQ-009 SHALL have port an  output  4  active-low anode selects; bit k drives digit k.
REQ-010 SHALL have port seg  output  7  active-low segments, ordered {g,f,e,d,c,b,a}.
REQ-011 SHALL have port dp  output  1  active-low decimal point.
REQ-012 SHALL have port frame  output  1  one-cycle pulse on the cycle digit 3's slot ends and digit 0's slot begins.

Function
REQ-013 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; the wrap cycle is the slot terminal.
REQ-014 Digit index SHALL advance 0->1->2->3->0 on each slot terminal; 3->0 wrap asserts frame for that cycle.
REQ-015 load high at edge N SHALL update the display register at edge N; any slot showing a digit from edge N+1 onward SHALL show the new value (outputs are registered, 1-cycle latency).
REQ-016 load SHALL be accepted any cycle, including mid-slot and on a terminal; no stall, no ready.
REQ-017 an SHALL be 4'b1111 while prescaler < GUARD; otherwise exactly one bit low, at the current digit index.
REQ-018 During the guard, seg SHALL be 7'h7F and dp SHALL be 1.
REQ-019 Decode (nibble -> seg): 0->1000000, 1->1111001, 2->0100100, 3->0110000, 4->0011001, 5->0010010, 6->0000010, 7->1111000, 8->0000000, 9->0010000.
REQ-020 Nibble values 10..15 SHALL display the dash 0111111 (g only); blank_lz SHALL treat them as nonzero.
REQ-021 When blank_lz=1, digit k (k=3..1) SHALL be blanked (seg=7'h7F, anode still driven) if it and every higher digit are zero.
REQ-022 Digit 0 SHALL never be blanked; all-zero value with blank_lz=1 displays a single "0".
REQ-023 dp SHALL be ~dp_en[k] for the active digit k, independent of blanking.
REQ-024 Changing blank_lz or dp_en SHALL take effect on the next registered output, with no effect on the scan position.

Reset
REQ-025 rst_n low at a rising edge SHALL force: prescaler=0, digit index=0, display register=16'h0000, an=4'b1111, seg=7'h7F, dp=1, frame=0.
REQ-026 Reset SHALL override load in the same cycle; an aborted slot restarts from digit 0 with a full guard.
REQ-027 First edge with rst_n high SHALL be prescaler count 0 of digit 0's slot.

Verification (REFRESH_DIV=8, GUARD=2 unless noted)
REQ-028 Reset, then load bcd=16'h1234, blank_lz=0 -> per slot after guard: an=1110/seg=0011001, an=1101/0110000, an=1011/0100100, an=0111/1111001; anodes 1111 for 2 cycles per slot.
REQ-029 load 16'h0042, blank_lz=1 -> digits 3,2 seg=7'h7F; digit 1 seg=0011001; digit 0 seg=0100100; load 16'h0000 -> only digit 0 shows 1000000.
REQ-030 load 16'h0A05, blank_lz=1 -> digit 3 blank, digit 2 dash 0111111, digit 1 shows 1000000 (not blanked), digit 0 shows 0010010.
REQ-031 load 16'h5555 mid-slot of digit 1 at cycle 5, dp_en=4'b0010 -> from cycle 6, digit-1 seg=0010010 and dp=0; other digits dp=1.
REQ-032 Free-run 64 cycles -> frame pulses exactly every 32 cycles, one cycle wide, coincident with the 3->0 wrap.
REQ-033 Assert rst_n=0 for one cycle together with load=1, bcd=16'h9999 during digit 2 -> next cycle an=1111, seg=7'h7F, display register 0; scan restarts at digit 0.
